// File: rtl/qupls_fpu_wb_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qupls_fpu_wb_seq_pkg
//  Description : Shared types for the FPU writeback sequencer. Holds the ROB
//                and register index types, the sequencer state encoding and
//                the default watchdog exception code.
//  Revision    : 1.0  initial release
// ============================================================================
package qupls_fpu_wb_seq_pkg;

   typedef logic [5:0]  rob_ndx_t;
   typedef logic [8:0]  pregno_t;
   typedef logic [6:0]  aregno_t;
   typedef logic [63:0] value_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CAP  = 3'd1,
      ST_WAIT = 3'd2,
      ST_WB0  = 3'd3,
      ST_WB1  = 3'd4
   } fpu_seq_state_t;

   localparam logic [7:0] FPU_EXC_TMO = 8'hFE;

endpackage
`default_nettype wire

// File: rtl/qupls_fpu_wb_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : qupls_fpu_wb_seq_if
//  Description : Writeback / completion bus between the FPU sequencer and the
//                FPU writeback arbiter.
//                master : sequencer  (drives wb_*, done_*; receives wb_ack)
//                slave  : arbiter    (receives wb_*, done_*; drives wb_ack)
//  Revision    : 1.0  initial release
// ============================================================================
interface qupls_fpu_wb_seq_if
   import qupls_fpu_wb_seq_pkg::*;
#(
   parameter int WID = 64
);
   logic           wb_v;
   pregno_t        wb_Rt;
   aregno_t        wb_aRt;
   logic           wb_aRtz;
   logic [WID-1:0] wb_res;
   logic           wb_ack;
   logic           done_v;
   rob_ndx_t       done_id;
   logic [7:0]     done_exc;

   modport master (
      output wb_v, wb_Rt, wb_aRt, wb_aRtz, wb_res,
      output done_v, done_id, done_exc,
      input  wb_ack
   );

   modport slave (
      input  wb_v, wb_Rt, wb_aRt, wb_aRtz, wb_res,
      input  done_v, done_id, done_exc,
      output wb_ack
   );

endinterface
`default_nettype wire

// File: rtl/qupls_fpu_wb_seq_byte_merge.sv
`default_nettype none
// ============================================================================
//  Module      : qupls_byte_merge
//  Description : Combinational per-byte lane select. A set mask bit keeps the
//                old byte, a clear bit takes the new byte.
//  Ports       : i_mask  lane select (1 = old)
//                i_old   old target value
//                i_new   freshly computed value
//                o_out   merged value
//  Revision    : 1.0  initial release
// ============================================================================
module qupls_byte_merge #(
   parameter int LANES = 8
) (
   input  wire logic [LANES-1:0]   i_mask,
   input  wire logic [8*LANES-1:0] i_old,
   input  wire logic [8*LANES-1:0] i_new,
   output logic      [8*LANES-1:0] o_out
);

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign o_out[8*gi +: 8] = i_mask[gi] ? i_old[8*gi +: 8] : i_new[8*gi +: 8];
   end

endmodule
`default_nettype wire

// File: rtl/qupls_fpu_wb_seq.sv
`default_nettype none
// ============================================================================
//  Module      : qupls_fpu_wb_seq
//  Description : FPU writeback sequencer. Takes the operand/target bundle
//                from the FPU reservation station, runs the FPU datapath
//                (single- or multi-cycle with watchdog), merges copy-target
//                byte lanes and issues one or two register-file writebacks
//                followed by a single ROB done pulse.
//  Ports       : clk, rst           clock, synchronous active-high reset
//                i_ld .. i_argT     station bundle (valid the cycle after i_ld)
//                i_flush            abort in-flight op
//                o_fpu_req          start pulse to FPU datapath
//                i_fpu_*            FPU datapath results
//                o_idle             station may issue while high
//                wb                 writeback / done bus (master side)
//  Revision    : 1.0  initial release
// ============================================================================
module qupls_fpu_wb_seq
   import qupls_fpu_wb_seq_pkg::*;
#(
   parameter int         WID     = 64,
   parameter int         TMO     = 255,
   parameter logic [7:0] EXC_TMO = FPU_EXC_TMO
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_ld,
   input  wire logic             i_multicycle,
   input  wire rob_ndx_t         i_id,
   input  wire pregno_t          i_Rt,
   input  wire pregno_t          i_Rt1,
   input  wire aregno_t          i_aRt,
   input  wire aregno_t          i_aRt1,
   input  wire logic             i_aRtz,
   input  wire logic             i_aRtz1,
   input  wire logic             i_qfext,
   input  wire logic [WID/8-1:0] i_cptgt,
   input  wire logic [WID-1:0]   i_argT,
   input  wire logic             i_flush,
   output logic                  o_fpu_req,
   input  wire logic             i_fpu_done,
   input  wire logic [WID-1:0]   i_fpu_res,
   input  wire logic [WID-1:0]   i_fpu_res1,
   input  wire logic [7:0]       i_fpu_exc,
   output logic                  o_idle,
   qupls_fpu_wb_seq_if.master    wb
);

   localparam int LANES = WID / 8;
   localparam int WDW   = $clog2(TMO + 1);

   fpu_seq_state_t   r_state;
   logic [WDW-1:0]   r_wdog;

   // captured bundle
   rob_ndx_t         r_id;
   pregno_t          r_Rt1;
   aregno_t          r_aRt1;
   logic             r_aRtz1;
   logic             r_qfext;
   logic [LANES-1:0] r_cptgt;
   logic [WID-1:0]   r_argT;

   // datapath results awaiting writeback
   logic [WID-1:0]   r_res;
   logic [WID-1:0]   r_res1;
   logic [7:0]       r_exc;

   // registered outputs
   logic             r_idle;
   logic             r_wb_v;
   pregno_t          r_wb_Rt;
   aregno_t          r_wb_aRt;
   logic             r_wb_aRtz;
   logic             r_wb_sel1;
   logic             r_done_v;
   rob_ndx_t         r_done_id;
   logic [7:0]       r_done_exc;

   logic [WID-1:0]   w_merge0;
   logic [WID-1:0]   w_merge1;

   qupls_byte_merge #(.LANES(LANES)) u_merge0 (
      .i_mask (r_cptgt),
      .i_old  (r_argT),
      .i_new  (r_res),
      .o_out  (w_merge0)
   );

   qupls_byte_merge #(.LANES(LANES)) u_merge1 (
      .i_mask (r_cptgt),
      .i_old  (r_argT),
      .i_new  (r_res1),
      .o_out  (w_merge1)
   );

   // The datapath is started while the bundle is on the station's outputs,
   // so a single-cycle result can be sampled at the end of this same cycle.
   assign o_fpu_req = (r_state == ST_CAP) && !(&i_cptgt) && !i_flush;

   assign o_idle      = r_idle;
   assign wb.wb_v     = r_wb_v;
   assign wb.wb_Rt    = r_wb_Rt;
   assign wb.wb_aRt   = r_wb_aRt;
   assign wb.wb_aRtz  = r_wb_aRtz;
   assign wb.wb_res   = r_wb_sel1 ? w_merge1 : w_merge0;
   assign wb.done_v   = r_done_v;
   assign wb.done_id  = r_done_id;
   assign wb.done_exc = r_done_exc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_wdog     <= '0;
         r_id       <= '0;
         r_Rt1      <= '0;
         r_aRt1     <= '0;
         r_aRtz1    <= 1'b0;
         r_qfext    <= 1'b0;
         r_cptgt    <= '0;
         r_argT     <= '0;
         r_res      <= '0;
         r_res1     <= '0;
         r_exc      <= '0;
         r_idle     <= 1'b1;
         r_wb_v     <= 1'b0;
         r_wb_Rt    <= '0;
         r_wb_aRt   <= '0;
         r_wb_aRtz  <= 1'b0;
         r_wb_sel1  <= 1'b0;
         r_done_v   <= 1'b0;
         r_done_id  <= '0;
         r_done_exc <= '0;
      end else if (i_flush) begin
         // Flush beats a same-cycle wb_ack and any coincident ld.
         r_state  <= ST_IDLE;
         r_idle   <= 1'b1;
         r_wb_v   <= 1'b0;
         r_done_v <= 1'b0;
      end else begin
         r_done_v <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_ld) begin
                  r_state <= ST_CAP;
                  r_idle  <= 1'b0;
               end
            end

            ST_CAP: begin
               r_id      <= i_id;
               r_Rt1     <= i_Rt1;
               r_aRt1    <= i_aRt1;
               r_aRtz1   <= i_aRtz1;
               r_qfext   <= i_qfext;
               r_cptgt   <= i_cptgt;
               r_argT    <= i_argT;
               r_wb_Rt   <= i_Rt;
               r_wb_aRt  <= i_aRt;
               r_wb_aRtz <= i_aRtz;
               r_wb_sel1 <= 1'b0;
               if (&i_cptgt) begin
                  // every lane is a copy: no datapath work needed
                  r_res   <= i_argT;
                  r_res1  <= i_argT;
                  r_exc   <= '0;
                  r_wb_v  <= 1'b1;
                  r_state <= ST_WB0;
               end else if (!i_multicycle) begin
                  r_res   <= i_fpu_res;
                  r_res1  <= i_fpu_res1;
                  r_exc   <= i_fpu_exc;
                  r_wb_v  <= 1'b1;
                  r_state <= ST_WB0;
               end else begin
                  r_wdog  <= '0;
                  r_state <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (i_fpu_done) begin
                  r_res   <= i_fpu_res;
                  r_res1  <= i_fpu_res1;
                  r_exc   <= i_fpu_exc;
                  r_wb_v  <= 1'b1;
                  r_state <= ST_WB0;
               end else if (r_wdog == WDW'(TMO)) begin
                  // watchdog: write back the old target unchanged
                  r_res   <= r_argT;
                  r_res1  <= r_argT;
                  r_exc   <= EXC_TMO;
                  r_wb_v  <= 1'b1;
                  r_state <= ST_WB0;
               end else begin
                  r_wdog <= r_wdog + WDW'(1);
               end
            end

            ST_WB0: begin
               if (wb.wb_ack) begin
                  if (r_qfext) begin
                     r_wb_Rt   <= r_Rt1;
                     r_wb_aRt  <= r_aRt1;
                     r_wb_aRtz <= r_aRtz1;
                     r_wb_sel1 <= 1'b1;
                     r_state   <= ST_WB1;
                  end else begin
                     r_wb_v     <= 1'b0;
                     r_done_v   <= 1'b1;
                     r_done_id  <= r_id;
                     r_done_exc <= r_exc;
                     r_idle     <= 1'b1;
                     r_state    <= ST_IDLE;
                  end
               end
            end

            ST_WB1: begin
               if (wb.wb_ack) begin
                  r_wb_v     <= 1'b0;
                  r_done_v   <= 1'b1;
                  r_done_id  <= r_id;
                  r_done_exc <= r_exc;
                  r_idle     <= 1'b1;
                  r_state    <= ST_IDLE;
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_idle  <= 1'b1;
               r_wb_v  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_qupls_fpu_wb_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qupls_fpu_wb_seq
//  Description : Directed self-checking bench for qupls_fpu_wb_seq.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_qupls_fpu_wb_seq;
   import qupls_fpu_wb_seq_pkg::*;

   logic        clk;
   logic        rst;
   logic        ld;
   logic        multicycle;
   rob_ndx_t    id;
   pregno_t     Rt, Rt1;
   aregno_t     aRt, aRt1;
   logic        aRtz, aRtz1;
   logic        qfext;
   logic [7:0]  cptgt;
   logic [63:0] argT;
   logic        flush;
   logic        fpu_req;
   logic        fpu_done;
   logic [63:0] fpu_res, fpu_res1;
   logic [7:0]  fpu_exc;
   logic        idle;

   int n_tests;
   int n_fail;

   qupls_fpu_wb_seq_if #(.WID(64)) wbif ();

   qupls_fpu_wb_seq #(.WID(64), .TMO(255), .EXC_TMO(8'hFE)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_ld         (ld),
      .i_multicycle (multicycle),
      .i_id         (id),
      .i_Rt         (Rt),
      .i_Rt1        (Rt1),
      .i_aRt        (aRt),
      .i_aRt1       (aRt1),
      .i_aRtz       (aRtz),
      .i_aRtz1      (aRtz1),
      .i_qfext      (qfext),
      .i_cptgt      (cptgt),
      .i_argT       (argT),
      .i_flush      (flush),
      .o_fpu_req    (fpu_req),
      .i_fpu_done   (fpu_done),
      .i_fpu_res    (fpu_res),
      .i_fpu_res1   (fpu_res1),
      .i_fpu_exc    (fpu_exc),
      .o_idle       (idle),
      .wb           (wbif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ld = 0; multicycle = 0; id = '0; Rt = '0; Rt1 = '0; aRt = '0; aRt1 = '0;
      aRtz = 0; aRtz1 = 0; qfext = 0; cptgt = '0; argT = '0; flush = 0;
      fpu_done = 0; fpu_res = '0; fpu_res1 = '0; fpu_exc = '0; wbif.wb_ack = 0;
   endtask

   // ld for one cycle; afterwards the sequencer is in its capture cycle
   task automatic pulse_ld();
      ld = 1;
      tick();
      ld = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1;
      tick(); tick();
      rst = 0;
      n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got=%b exp=1", idle); end
      n_tests++; if (fpu_req !== 1'b0) begin n_fail++; $display("FAIL reset_fpu_req got=%b exp=0", fpu_req); end
      n_tests++; if (wbif.wb_v !== 1'b0 || wbif.done_v !== 1'b0 || wbif.wb_aRtz !== 1'b0) begin
         n_fail++; $display("FAIL reset_valids got wb_v=%b done_v=%b aRtz=%b exp 0/0/0", wbif.wb_v, wbif.done_v, wbif.wb_aRtz); end
      n_tests++; if (wbif.wb_res !== 64'h0 || wbif.wb_Rt !== 9'h0 || wbif.done_exc !== 8'h0 || wbif.done_id !== 6'h0) begin
         n_fail++; $display("FAIL reset_data got res=%h Rt=%h exc=%h id=%h exp all 0", wbif.wb_res, wbif.wb_Rt, wbif.done_exc, wbif.done_id); end
   endtask

   task automatic test_single();
      clear_inputs();
      id = 6'd5; Rt = 9'h021; aRt = 7'h11; cptgt = 8'h00; argT = 64'hFFFF_0000_FFFF_0000;
      fpu_res = 64'h1122334455667788; wbif.wb_ack = 1;
      pulse_ld();
      n_tests++; if (idle !== 1'b0) begin n_fail++; $display("FAIL single_idle_drop got=%b exp=0", idle); end
      n_tests++; if (fpu_req !== 1'b1) begin n_fail++; $display("FAIL single_fpu_req got=%b exp=1", fpu_req); end
      tick();
      n_tests++; if (wbif.wb_v !== 1'b1 || wbif.wb_res !== 64'h1122334455667788 || wbif.wb_Rt !== 9'h021 || wbif.wb_aRt !== 7'h11) begin
         n_fail++; $display("FAIL single_wb got v=%b res=%h Rt=%h aRt=%h exp 1/1122334455667788/021/11", wbif.wb_v, wbif.wb_res, wbif.wb_Rt, wbif.wb_aRt); end
      n_tests++; if (fpu_req !== 1'b0) begin n_fail++; $display("FAIL single_req_once got=%b exp=0", fpu_req); end
      tick();
      n_tests++; if (wbif.done_v !== 1'b1 || wbif.done_id !== 6'd5 || wbif.done_exc !== 8'h00) begin
         n_fail++; $display("FAIL single_done got v=%b id=%0d exc=%h exp 1/5/00", wbif.done_v, wbif.done_id, wbif.done_exc); end
      n_tests++; if (idle !== 1'b1 || wbif.wb_v !== 1'b0) begin
         n_fail++; $display("FAIL single_idle_back got idle=%b wb_v=%b exp 1/0", idle, wbif.wb_v); end
      wbif.wb_ack = 0;
      tick();
      n_tests++; if (wbif.done_v !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse got=%b exp=0", wbif.done_v); end
   endtask

   task automatic test_merge();
      clear_inputs();
      id = 6'd7; cptgt = 8'h0F; argT = 64'hAAAAAAAAAAAAAAAA; fpu_res = 64'h1111111111111111;
      wbif.wb_ack = 1;
      pulse_ld();
      tick();
      n_tests++; if (wbif.wb_res !== 64'h11111111AAAAAAAA) begin
         n_fail++; $display("FAIL merge_0F got=%h exp=11111111aaaaaaaa", wbif.wb_res); end
      tick();
      n_tests++; if (wbif.done_v !== 1'b1 || wbif.done_id !== 6'd7) begin
         n_fail++; $display("FAIL merge_done got v=%b id=%0d exp 1/7", wbif.done_v, wbif.done_id); end
      wbif.wb_ack = 0;
      tick();
   endtask

   task automatic test_all_copy();
      clear_inputs();
      id = 6'd9; cptgt = 8'hFF; multicycle = 1; argT = 64'hDEADBEEF01234567;
      fpu_res = 64'h5555555555555555; fpu_exc = 8'h55;
      pulse_ld();
      n_tests++; if (fpu_req !== 1'b0) begin n_fail++; $display("FAIL copy_no_req got=%b exp=0", fpu_req); end
      tick();
      n_tests++; if (wbif.wb_v !== 1'b1 || wbif.wb_res !== 64'hDEADBEEF01234567 || fpu_req !== 1'b0) begin
         n_fail++; $display("FAIL copy_wb got v=%b res=%h req=%b exp 1/deadbeef01234567/0", wbif.wb_v, wbif.wb_res, fpu_req); end
      wbif.wb_ack = 1;
      tick();
      n_tests++; if (wbif.done_v !== 1'b1 || wbif.done_exc !== 8'h00) begin
         n_fail++; $display("FAIL copy_done got v=%b exc=%h exp 1/00", wbif.done_v, wbif.done_exc); end
      wbif.wb_ack = 0;
      tick();
   endtask

   task automatic test_timeout();
      int cnt;
      clear_inputs();
      id = 6'd12; multicycle = 1; cptgt = 8'h00; argT = 64'h0123456789ABCDEF;
      fpu_res = 64'h9999999999999999;
      pulse_ld();
      n_tests++; if (fpu_req !== 1'b1) begin n_fail++; $display("FAIL tmo_req got=%b exp=1", fpu_req); end
      cnt = 0;
      for (int i = 0; i < 400; i++) begin
         tick();
         cnt++;
         if (wbif.wb_v === 1'b1) break;
      end
      // cnt-1 is the number of cycles spent waiting
      n_tests++; if (wbif.wb_v !== 1'b1 || cnt < 256 || cnt > 257) begin
         n_fail++; $display("FAIL tmo_latency got wb_v=%b cycles=%0d exp wb_v=1 cycles 256..257", wbif.wb_v, cnt); end
      n_tests++; if (wbif.wb_res !== 64'h0123456789ABCDEF) begin
         n_fail++; $display("FAIL tmo_res got=%h exp=0123456789abcdef", wbif.wb_res); end
      wbif.wb_ack = 1;
      tick();
      n_tests++; if (wbif.done_v !== 1'b1 || wbif.done_exc !== 8'hFE || wbif.done_id !== 6'd12) begin
         n_fail++; $display("FAIL tmo_done got v=%b exc=%h id=%0d exp 1/fe/12", wbif.done_v, wbif.done_exc, wbif.done_id); end
      wbif.wb_ack = 0;
      tick();
   endtask

   task automatic test_qfext_stall();
      int ndone;
      clear_inputs();
      id = 6'h2A; qfext = 1; cptgt = 8'h01; argT = 64'hFFFFFFFFFFFFFFFF;
      Rt = 9'h040; Rt1 = 9'h041; aRt = 7'h20; aRt1 = 7'h21; aRtz = 0; aRtz1 = 1;
      fpu_res = 64'h1234567812345678; fpu_res1 = 64'h8765432187654321; fpu_exc = 8'h03;
      pulse_ld();
      tick();
      for (int i = 0; i < 4; i++) begin
         n_tests++; if (wbif.wb_v !== 1'b1 || wbif.wb_Rt !== 9'h040 || wbif.wb_res !== 64'h12345678123456FF || wbif.done_v !== 1'b0) begin
            n_fail++; $display("FAIL qfext_hold%0d got v=%b Rt=%h res=%h done=%b exp 1/040/12345678123456ff/0", i, wbif.wb_v, wbif.wb_Rt, wbif.wb_res, wbif.done_v); end
         if (i < 3) tick();
      end
      wbif.wb_ack = 1;
      tick();
      n_tests++; if (wbif.wb_v !== 1'b1 || wbif.wb_Rt !== 9'h041 || wbif.wb_aRt !== 7'h21 || wbif.wb_aRtz !== 1'b1 ||
                     wbif.wb_res !== 64'h87654321876543FF || wbif.done_v !== 1'b0) begin
         n_fail++; $display("FAIL qfext_wb1 got v=%b Rt=%h aRt=%h z=%b res=%h done=%b exp 1/041/21/1/87654321876543ff/0",
                            wbif.wb_v, wbif.wb_Rt, wbif.wb_aRt, wbif.wb_aRtz, wbif.wb_res, wbif.done_v); end
      tick();
      n_tests++; if (wbif.done_v !== 1'b1 || wbif.done_id !== 6'h2A || wbif.done_exc !== 8'h03 || idle !== 1'b1) begin
         n_fail++; $display("FAIL qfext_done got v=%b id=%h exc=%h idle=%b exp 1/2a/03/1", wbif.done_v, wbif.done_id, wbif.done_exc, idle); end
      wbif.wb_ack = 0;
      ndone = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (wbif.done_v === 1'b1) ndone++;
      end
      n_tests++; if (ndone !== 0) begin n_fail++; $display("FAIL qfext_single_done extra=%0d exp=0", ndone); end
   endtask

   task automatic test_flush_wait();
      int nbad;
      clear_inputs();
      id = 6'd3; multicycle = 1; cptgt = 8'h00; wbif.wb_ack = 1;
      pulse_ld();
      tick(); tick();
      flush = 1;
      tick();
      flush = 0;
      n_tests++; if (idle !== 1'b1 || wbif.wb_v !== 1'b0) begin
         n_fail++; $display("FAIL flush_idle got idle=%b wb_v=%b exp 1/0", idle, wbif.wb_v); end
      fpu_done = 1; fpu_res = 64'h7777777777777777;
      tick();
      fpu_done = 0;
      nbad = 0;
      for (int i = 0; i < 4; i++) begin
         if (wbif.wb_v === 1'b1 || wbif.done_v === 1'b1 || idle !== 1'b1) nbad++;
         tick();
      end
      n_tests++; if (nbad !== 0) begin n_fail++; $display("FAIL flush_late_done bad_cycles=%0d exp=0", nbad); end
      wbif.wb_ack = 0;
   endtask

   task automatic test_flush_ack();
      clear_inputs();
      id = 6'd14; fpu_res = 64'h0102030405060708;
      pulse_ld();
      tick();
      wbif.wb_ack = 1; flush = 1;
      tick();
      wbif.wb_ack = 0; flush = 0;
      n_tests++; if (wbif.done_v !== 1'b0 || wbif.wb_v !== 1'b0 || idle !== 1'b1) begin
         n_fail++; $display("FAIL flush_ack got done=%b wb_v=%b idle=%b exp 0/0/1", wbif.done_v, wbif.wb_v, idle); end
      ld = 1; flush = 1;
      tick();
      ld = 0; flush = 0;
      n_tests++; if (idle !== 1'b1 || fpu_req !== 1'b0) begin
         n_fail++; $display("FAIL flush_ld got idle=%b req=%b exp 1/0", idle, fpu_req); end
      tick();
   endtask

   task automatic test_back_to_back();
      clear_inputs();
      id = 6'd20; fpu_res = 64'hA5A5A5A5A5A5A5A5; wbif.wb_ack = 1;
      pulse_ld(); tick(); tick();
      id = 6'd21; fpu_res = 64'h5A5A5A5A5A5A5A5A;
      pulse_ld();
      n_tests++; if (fpu_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req got=%b exp=1", fpu_req); end
      tick();
      n_tests++; if (wbif.wb_res !== 64'h5A5A5A5A5A5A5A5A) begin
         n_fail++; $display("FAIL b2b_res got=%h exp=5a5a5a5a5a5a5a5a", wbif.wb_res); end
      tick();
      n_tests++; if (wbif.done_v !== 1'b1 || wbif.done_id !== 6'd21) begin
         n_fail++; $display("FAIL b2b_done got v=%b id=%0d exp 1/21", wbif.done_v, wbif.done_id); end
      wbif.wb_ack = 0;
      tick();
   endtask

   task automatic test_reset_midop();
      clear_inputs();
      id = 6'd30; Rt = 9'h1FF; fpu_res = 64'hCAFEBABECAFEBABE;
      pulse_ld(); tick();
      rst = 1;
      tick();
      rst = 0;
      n_tests++; if (wbif.wb_v !== 1'b0 || idle !== 1'b1 || wbif.wb_res !== 64'h0 || wbif.wb_Rt !== 9'h0 || wbif.done_v !== 1'b0) begin
         n_fail++; $display("FAIL reset_midop got v=%b idle=%b res=%h Rt=%h done=%b exp 0/1/0/0/0", wbif.wb_v, idle, wbif.wb_res, wbif.wb_Rt, wbif.done_v); end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1;
      clear_inputs();
      test_reset();
      test_single();
      test_merge();
      test_all_copy();
      test_timeout();
      test_qfext_stall();
      test_flush_wait();
      test_flush_ack();
      test_back_to_back();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
